addsub_bist: RTL

- Hardware self-test controller that drives the operand side of the 4-bit `adder_subtractor` and checks its results.
- After a start pulse it sweeps every (A, B, mode) combination exhaustively and compares each DUT result against an internal golden model.
- It counts mismatches, captures the first failing vector, and reports pass/fail.
- It sits beside `adder_subtractor` in the top level so the datapath can be verified on silicon or FPGA without an HDL bench.

---
 rtl/addsub_bist_pkg.sv | 33 +++
 rtl/addsub_ref_model.sv | 27 ++
 rtl/addsub_bist.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/addsub_bist_pkg.sv
// Shared types and helpers for the adder/subtractor self-test controller.
// The golden model works at a fixed maximum width and masks down to the operand width in use.
package addsub_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 16;

  // Number of (A, B, mode) vectors in an exhaustive sweep.
  function automatic int nvec(input int width);
    return 1 << (2 * width + 1);
  endfunction

  // {carry, result} of A + (B ^ {mode}) + mode; the result fits in width+1 bits.
  function automatic logic [MAX_W:0] addsub_expected(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b,
                                                     input logic             mode,
                                                     input int               width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] a_m;
    logic [MAX_W-1:0] b_m;
    mask = '1;
    mask = mask >> (MAX_W - width);
    a_m  = a & mask;
    b_m  = (b ^ {MAX_W{mode}}) & mask;
    return {1'b0, a_m} + {1'b0, b_m} + {{MAX_W{1'b0}}, mode};
  endfunction

endpackage

// File: rtl/addsub_ref_model.sv
// Combinational golden model of a WIDTH-bit adder/subtractor.
// Subtract carry is the carry-out of A + ~B + 1, so 1 means no borrow.
module addsub_ref_model
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic [WIDTH:0]   o_expected
);

  logic [MAX_W:0] w_full;

  assign w_full     = addsub_expected(MAX_W'(i_a), MAX_W'(i_b), i_mode, WIDTH);
  assign o_expected = w_full[WIDTH:0];

  // Bits above WIDTH are always zero after masking.
  generate
    if (WIDTH < MAX_W) begin : g_upper
      logic w_unused;
      assign w_unused = |w_full[MAX_W:WIDTH+1];
    end
  endgenerate

endmodule

// File: rtl/addsub_bist.sv
// Exhaustive self-test controller for a WIDTH-bit adder/subtractor: sweeps every
// (A, B, mode) vector, compares against the golden model, counts and captures mismatches.
module addsub_bist
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_mode,
  input  logic [WIDTH-1:0]   dut_out,
  input  logic               dut_carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_mode
);

  localparam int IW = 2 * WIDTH + 1;
  localparam int CW = 2 * WIDTH + 2;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] LAST_IDX    = IW'(nvec(WIDTH) - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_settle;
  logic [CW-1:0]    r_err_count;
  logic             r_fail_valid;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic             r_fail_mode;

  logic             w_start_sweep;
  logic             w_sample;
  logic             w_last;
  logic             w_mismatch;
  logic [WIDTH:0]   w_expected;

  // The driven vector is the index itself: mode is the MSB, B the fastest-moving field.
  assign dut_mode = r_idx[IW-1];
  assign dut_a    = r_idx[IW-2:WIDTH];
  assign dut_b    = r_idx[WIDTH-1:0];

  addsub_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .i_a        (dut_a),
    .i_b        (dut_b),
    .i_mode     (dut_mode),
    .o_expected (w_expected)
  );

  assign w_start_sweep = (r_state != RUN) && start;
  assign w_sample      = (r_state == RUN) && (r_settle == SETTLE_LAST);
  assign w_last        = (r_idx == LAST_IDX);
  assign w_mismatch    = ({dut_carry, dut_out} != w_expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_sample && w_last) w_state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_settle     <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_mode  <= 1'b0;
    end else if (w_start_sweep) begin
      r_idx        <= '0;
      r_settle     <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_mode  <= 1'b0;
    end else if (r_state == RUN) begin
      if (!w_sample) begin
        r_settle <= r_settle + SW'(1);
      end else begin
        if (w_mismatch) begin
          r_err_count <= r_err_count + CW'(1);
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_a     <= dut_a;
            r_fail_b     <= dut_b;
            r_fail_mode  <= dut_mode;
          end
        end
        // The final vector stays on dut_* once the sweep finishes.
        if (!w_last) begin
          r_idx    <= r_idx + IW'(1);
          r_settle <= '0;
        end
      end
    end
  end

  assign pass       = done && (r_err_count == '0);
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;
  assign fail_mode  = r_fail_mode;

endmodule
